tile_ram_arbiter: RTL
=====================

# tile_ram_arbiter

Single-port access arbiter for the tileset RAM. It shares one RAM port between two requesters. The display pixel pipeline is the first; it issues tile-pixel reads at up to one per cycle and must see fixed latency. The game-logic updater is the second; it issues sporadic reads and writes for animation or maze edits through a req/ack handshake. The block sits between the memory controller's tile-address path and the tileset RAM instance.

## Interface
Parameters:
- ADDR_W, 12, tileset RAM address width (64 tiles × 64 pixels)
- DATA_W, 4, palette-index width
- STARVE_MAX, 255, update-pending cycles before a forced update slot (used only with the guard compiled in)

Ports:
- i_clk  in  1  single clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_disp_req  in  1  display read request this cycle
- i_disp_addr  in  ADDR_W  display read address
- o_disp_valid  out  1  display read data valid
- o_disp_data  out  DATA_W  display read data
- o_disp_miss  out  1  display request dropped for a forced update
- i_upd_req  in  1  updater request, level, held until ack
- i_upd_we  in  1  1 = write, 0 = read; stable while req
- i_upd_addr  in  ADDR_W  updater address; stable while req
- i_upd_wdata  in  DATA_W  updater write data; stable while req
- o_upd_ack  out  1  one-cycle completion pulse
- o_upd_rdata  out  DATA_W  read data, valid with ack when i_upd_we = 0
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_data  out  DATA_W  RAM write data
- o_ram_wren  out  1  RAM write enable
- i_ram_q  in  DATA_W  RAM read data, one cycle after address

## Operation
- One RAM access per cycle. The RAM outputs are combinational from the grant decision. The RAM has a 1-cycle registered read.
- FSM states:
  - S_IDLE: updater may be granted.
  - S_UPD_ACK: updater was issued last cycle. The ack goes out this cycle. i_upd_req is ignored this cycle.
- FSM transitions: S_IDLE → S_UPD_ACK on updater grant. S_UPD_ACK → S_IDLE unconditionally.
- Grant rule:
  - The display wins whenever i_disp_req = 1, except on a forced slot.
  - The updater is granted when i_upd_req = 1, state = S_IDLE, and (i_disp_req = 0 or forced slot).
- When nothing is granted: o_ram_wren = 0 and o_ram_addr = 0.
- Display path: the grant is registered. In the next cycle, o_disp_valid = 1 and o_disp_data = i_ram_q.
- Updater path:
  - A write drives o_ram_wren = 1 in the grant cycle only.
  - In the next cycle, o_upd_ack = 1. For a read, o_upd_rdata = i_ram_q in that cycle; for a write, o_upd_rdata holds its previous value.
  - The requester may drop req or present a new request in the cycle after ack.
- A forced slot with i_disp_req = 1 means the display request is discarded. o_disp_miss = 1 in the cycle where o_disp_valid would have risen, and o_disp_valid = 0 in that cycle.

## Timing
- Reset values: all outputs 0, FSM = S_IDLE, starvation counter = 0.
- Latency:
  - Display: request to valid is exactly 1 cycle; back-to-back requests give back-to-back valids.
  - Updater: req to ack is at least 1 cycle when the display is idle, 2 cycles minimum between consecutive updates.
- Simultaneous display and updater requests: display wins, except on a forced slot.
- Updater requests arriving during S_UPD_ACK are not sampled.
- Reset asserted mid-operation:
  - An in-flight update produces no ack.
  - An in-flight display read produces no valid.
  - Pending requests must be re-presented after reset.
- Address wrap: none. Addresses are used as given, ADDR_W bits.

## Configuration
- TILE_ARB_STARVE_GUARD_EN defined:
  - A saturating counter (width clog2(STARVE_MAX+1)) increments each cycle that i_upd_req = 1, the FSM is in S_IDLE, and the updater is not granted.
  - The counter clears on updater grant and whenever i_upd_req = 0.
  - When the counter equals STARVE_MAX, the next eligible cycle is a forced slot.
- Undefined:
  - Strict display priority; the updater can starve indefinitely.
  - o_disp_miss is tied to 0.
  - STARVE_MAX is ignored.

## Structure
- Package tile_ram_pkg:
  - ADDR_W and DATA_W defaults
  - the FSM state enum (S_IDLE, S_UPD_ACK)
  - STARVE_MAX default
- Sub-module arb_starve_counter: the saturating counter plus the forced-slot compare. It is instantiated only under TILE_ARB_STARVE_GUARD_EN.
- The RAM itself is external and not instantiated here.

## Test plan
- Display stream: i_disp_req = 1 for 64 cycles, addresses 0x040..0x07F, RAM preloaded with addr[3:0] → 64 consecutive o_disp_valid, each one cycle late, data = addr[3:0], o_disp_miss never set.
- Updater write with display idle: addr 0x123, wdata 0xA → o_ram_wren for 1 cycle, o_upd_ack next cycle; a subsequent read of 0x123 acks with o_upd_rdata = 0xA.
- Contention: display and updater request together for 5 cycles, then display drops → updater granted in cycle 5, ack in cycle 6, no display valid lost.
- Starvation (guard on, STARVE_MAX = 4): continuous display requests plus an updater read → 4 wait cycles, forced slot on the 5th, one o_disp_miss pulse, ack next cycle. With the guard off: no ack while display is busy.
- Reset mid-update: i_rst_n low in the grant cycle → no ack, all outputs 0, FSM = S_IDLE after release.

Source files
------------

// File: rtl/tile_ram_pkg.sv
// ---------------------------------------------------------------------------
// tile_ram_pkg
//
// Shared definitions for the tileset RAM arbiter:
//   - default address / data widths of the tileset RAM
//     (64 tiles x 64 pixels, 4-bit palette indices)
//   - default starvation limit for the optional update guard
//   - arbiter FSM state encoding
//   - helper that sizes the starvation counter
// ---------------------------------------------------------------------------
package tile_ram_pkg;

    // Default geometry of the tileset RAM
    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 4;

    // Default number of blocked update cycles before a forced update slot
    localparam int STARVE_MAX_DEF = 255;

    // Arbiter FSM: S_UPD_ACK is the single cycle in which an updater access
    // completes; the updater request line is not looked at in that cycle.
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_UPD_ACK = 1'b1
    } arb_state_t;

    // Width needed to count from 0 up to max_val inclusive. Never returns 0
    // so that a degenerate limit still yields a legal vector.
    function automatic int starve_cnt_w(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
//
// Tracks how long a pending updater request has been blocked by display
// traffic and flags a forced update slot once the limit is reached.
//
// Ports:
//   clk        in   clock, state on rising edge
//   rst_n      in   asynchronous active-low reset
//   upd_req    in   updater request level
//   idle       in   arbiter is able to grant the updater this cycle
//   upd_grant  in   updater was granted this cycle
//   forced     out  this cycle is a forced update slot
//
// Parameters:
//   STARVE_MAX number of blocked eligible cycles tolerated before forcing
// ---------------------------------------------------------------------------
module arb_starve_counter
    import tile_ram_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic upd_req,
    input  logic idle,
    input  logic upd_grant,
    output logic forced
);

    localparam int              CNT_W   = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count;

    // Count only cycles in which the updater could have been served but was
    // not. A dropped request or a grant restarts the wait. The count sits at
    // its limit until the forced slot is taken, and simply holds during the
    // ack cycle where the request is not looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (upd_grant || !upd_req) begin
            count <= '0;
        end else if (idle && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // The first eligible cycle after reaching the limit is the forced slot.
    assign forced = upd_req && idle && (count == CNT_MAX);

endmodule

// File: rtl/tile_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tile_ram_arbiter
//
// Shares the single tileset RAM port between the display pixel pipeline
// (fixed one-cycle read latency, up to one read per cycle) and the game-logic
// updater (sporadic reads/writes through a level req / one-cycle ack).
// The display has priority; the updater is served on free cycles.
//
// Build option:
//   TILE_ARB_STARVE_GUARD_EN  when defined, a blocked updater is guaranteed a
//                             slot after STARVE_MAX eligible cycles; the
//                             display read in that slot is dropped and
//                             reported on o_disp_miss. When undefined the
//                             display has strict priority and o_disp_miss
//                             is always 0.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_disp_req/addr        display read request and address
//   o_disp_valid/data      display read result, one cycle after the request
//   o_disp_miss            display read dropped in favour of a forced update
//   i_upd_req/we/addr/wdata updater request, held until o_upd_ack
//   o_upd_ack              one-cycle completion pulse
//   o_upd_rdata            updater read data (valid with ack on reads,
//                          holds its last value otherwise)
//   o_ram_addr/data/wren   RAM port, combinational from the grant decision
//   i_ram_q                RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module tile_ram_arbiter
    import tile_ram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_miss,

    input  logic              i_upd_req,
    input  logic              i_upd_we,
    input  logic [ADDR_W-1:0] i_upd_addr,
    input  logic [DATA_W-1:0] i_upd_wdata,
    output logic              o_upd_ack,
    output logic [DATA_W-1:0] o_upd_rdata,

    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_ram_wren,
    input  logic [DATA_W-1:0] i_ram_q
);

    arb_state_t        state;
    arb_state_t        state_next;

    logic              idle;
    logic              forced;
    logic              upd_grant;
    logic              disp_grant;

    logic              disp_pending;
    logic              upd_rd_pending;
    logic [DATA_W-1:0] rdata_hold;

    assign idle = (state == S_IDLE);

`ifdef TILE_ARB_STARVE_GUARD_EN
    logic miss_pending;

    arb_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .upd_req    (i_upd_req),
        .idle       (idle),
        .upd_grant  (upd_grant),
        .forced     (forced)
    );

    // A display request that lost its slot to a forced update is reported
    // in the cycle its data would otherwise have appeared.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            miss_pending <= 1'b0;
        end else begin
            miss_pending <= forced && i_disp_req;
        end
    end

    assign o_disp_miss = miss_pending;
`else
    assign forced      = 1'b0;
    assign o_disp_miss = 1'b0;
`endif

    // Grant decision and RAM port drive. The updater only goes through when
    // the display is quiet or the slot is forced; an unused port is parked
    // at address 0 with writes disabled.
    always_comb begin
        upd_grant  = i_upd_req && idle && (!i_disp_req || forced);
        disp_grant = i_disp_req && !forced;

        o_ram_addr = '0;
        o_ram_data = '0;
        o_ram_wren = 1'b0;

        if (upd_grant) begin
            o_ram_addr = i_upd_addr;
            o_ram_wren = i_upd_we;
            if (i_upd_we) begin
                o_ram_data = i_upd_wdata;
            end
        end else if (disp_grant) begin
            o_ram_addr = i_disp_addr;
        end
    end

    // FSM next state: one ack cycle follows every updater grant, which also
    // enforces the two-cycle spacing between updates.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (upd_grant) begin
                    state_next = S_UPD_ACK;
                end
            end
            S_UPD_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember what was issued this cycle so the matching RAM data can be
    // steered to the right requester next cycle. The updater read result is
    // captured so o_upd_rdata keeps it after the ack (and across writes).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp_pending   <= 1'b0;
            upd_rd_pending <= 1'b0;
            rdata_hold     <= '0;
        end else begin
            disp_pending   <= disp_grant;
            upd_rd_pending <= upd_grant && !i_upd_we;
            if (o_upd_ack && upd_rd_pending) begin
                rdata_hold <= i_ram_q;
            end
        end
    end

    assign o_disp_valid = disp_pending;
    assign o_disp_data  = disp_pending ? i_ram_q : '0;
    assign o_upd_ack    = (state == S_UPD_ACK);
    assign o_upd_rdata  = (o_upd_ack && upd_rd_pending) ? i_ram_q : rdata_hold;

endmodule
